// File: rtl/pulse_stats_if.sv
// Bus bundle between the duration measurement stage, pulse_stats and the readout logic.
interface pulse_stats_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LOG2_N = 2
);
  logic [DW-1:0]     dur_in;
  logic              dur_valid;
  logic              clear;
  logic              stat_valid;
  logic              stat_ready;
  logic [DW-1:0]     min_out;
  logic [DW-1:0]     max_out;
  logic [DW-1:0]     avg_out;
  logic              overrun;
  logic [LOG2_N:0]   fill;

  // Producer / consumer side (stimulus and readout).
  modport master (
    output dur_in, dur_valid, clear, stat_ready,
    input  stat_valid, min_out, max_out, avg_out, overrun, fill
  );

  // Statistics block side.
  modport slave (
    input  dur_in, dur_valid, clear, stat_ready,
    output stat_valid, min_out, max_out, avg_out, overrun, fill
  );
endinterface

// File: rtl/pulse_stats.sv
// Windowed min/max/mean of non-zero pulse durations with a valid/ready result register.
module pulse_stats #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LOG2_N = 2
) (
  input  logic          clk,
  input  logic          reset,
  pulse_stats_if.slave  bus
);

  localparam int unsigned SW = DW + LOG2_N;
  localparam int unsigned CW = LOG2_N + 1;
  localparam logic [CW-1:0] LastCnt = CW'((1 << LOG2_N) - 1);

  // Accumulator state
  logic [SW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] max_q, max_d;

  // Result register state
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic [DW-1:0] res_min_q, res_min_d;
  logic [DW-1:0] res_max_q, res_max_d;
  logic [DW-1:0] res_avg_q, res_avg_d;

  logic          accept;
  logic          win_done;
  logic          load;
  logic [SW-1:0] sum_add;
  logic [DW-1:0] min_upd;
  logic [DW-1:0] max_upd;

  // Sample qualification and running values including the incoming sample
  always_comb begin
    accept   = bus.dur_valid && (bus.dur_in != '0) && !bus.clear;
    sum_add  = sum_q + SW'(bus.dur_in);
    min_upd  = (bus.dur_in < min_q) ? bus.dur_in : min_q;
    max_upd  = (bus.dur_in > max_q) ? bus.dur_in : max_q;
    win_done = accept && (cnt_q == LastCnt);
    // A completed window lands only if the register is empty or draining this cycle.
    load     = win_done && (!valid_q || bus.stat_ready);
  end

  // Accumulator next state: restart on clear or window completion
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    min_d = min_q;
    max_d = max_q;
    if (bus.clear || win_done) begin
      sum_d = '0;
      cnt_d = '0;
      min_d = '1;
      max_d = '0;
    end else if (accept) begin
      sum_d = sum_add;
      cnt_d = cnt_q + 1'b1;
      min_d = min_upd;
      max_d = max_upd;
    end
  end

  // Result register next state: handshake, load, overrun
  always_comb begin
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    res_min_d = res_min_q;
    res_max_d = res_max_q;
    res_avg_d = res_avg_q;
    if (bus.clear) begin
      // Held values stay visible; only the flags are reset.
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (valid_q && bus.stat_ready) valid_d = 1'b0;
      if (load) begin
        valid_d   = 1'b1;
        res_min_d = min_upd;
        res_max_d = max_upd;
        res_avg_d = DW'(sum_add >> LOG2_N);
      end else if (win_done) begin
        ovr_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q     <= '0;
      cnt_q     <= '0;
      min_q     <= '1;
      max_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      res_min_q <= '0;
      res_max_q <= '0;
      res_avg_q <= '0;
    end else begin
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
      res_avg_q <= res_avg_d;
    end
  end

  // Outputs driven straight from registers
  always_comb begin
    bus.stat_valid = valid_q;
    bus.overrun    = ovr_q;
    bus.min_out    = res_min_q;
    bus.max_out    = res_max_q;
    bus.avg_out    = res_avg_q;
    bus.fill       = cnt_q;
  end

endmodule

// File: tb/tb_pulse_stats.sv
// Self-checking bench for pulse_stats: directed vector table, hand sequences, random vs model.
module tb_pulse_stats;

  localparam int unsigned DW     = 8;
  localparam int unsigned LOG2_N = 2;
  localparam int unsigned N      = 1 << LOG2_N;

  logic clk = 1'b0;
  logic reset;

  pulse_stats_if #(.DW(DW), .LOG2_N(LOG2_N)) bus ();

  pulse_stats #(.DW(DW), .LOG2_N(LOG2_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending window as a list of samples, plus result register contents.
  int m_win[$];
  int m_valid, m_min, m_max, m_avg, m_ovr;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       c;
    logic       r;
    int         ev, emin, emax, eavg, eovr, efill;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_win.delete();
    m_valid = 0; m_min = 0; m_max = 0; m_avg = 0; m_ovr = 0;
  endfunction

  // Applies one clock edge of the rules to the model.
  function automatic void model_edge(logic v, logic [7:0] d, logic c, logic r);
    int mn, mx, s;
    bit was_valid;
    if (c) begin
      m_win.delete();
      m_valid = 0;
      m_ovr   = 0;
      return;
    end
    was_valid = (m_valid != 0);
    if (was_valid && r) m_valid = 0;
    if (v && d != 0) begin
      m_win.push_back(int'(d));
      if (m_win.size() == N) begin
        mn = 1 << 30; mx = 0; s = 0;
        foreach (m_win[i]) begin
          if (m_win[i] < mn) mn = m_win[i];
          if (m_win[i] > mx) mx = m_win[i];
          s += m_win[i];
        end
        m_win.delete();
        if (!was_valid || r) begin
          m_valid = 1; m_min = mn; m_max = mx; m_avg = s / N;
        end else begin
          m_ovr = 1;
        end
      end
    end
  endfunction

  function automatic void check_model(string tag);
    chk({tag, ".stat_valid"}, 32'(bus.stat_valid), 32'(m_valid));
    chk({tag, ".min_out"},    32'(bus.min_out),    32'(m_min));
    chk({tag, ".max_out"},    32'(bus.max_out),    32'(m_max));
    chk({tag, ".avg_out"},    32'(bus.avg_out),    32'(m_avg));
    chk({tag, ".overrun"},    32'(bus.overrun),    32'(m_ovr));
    chk({tag, ".fill"},       32'(bus.fill),       32'(m_win.size()));
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic c, input logic r,
                      input string tag);
    bus.dur_valid  = v;
    bus.dur_in     = d;
    bus.clear      = c;
    bus.stat_ready = r;
    @(posedge clk);
    #1;
    model_edge(v, d, c, r);
    check_model(tag);
  endtask

  task automatic check_zero_outputs(string tag);
    chk({tag, ".stat_valid"}, 32'(bus.stat_valid), 32'd0);
    chk({tag, ".min_out"},    32'(bus.min_out),    32'd0);
    chk({tag, ".max_out"},    32'(bus.max_out),    32'd0);
    chk({tag, ".avg_out"},    32'(bus.avg_out),    32'd0);
    chk({tag, ".overrun"},    32'(bus.overrun),    32'd0);
    chk({tag, ".fill"},       32'(bus.fill),       32'd0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_reset(string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero_outputs(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic void add(logic v, logic [7:0] d, logic c, logic r,
                              int ev, int emin, int emax, int eavg, int eovr, int efill);
    vec_t e;
    e.v = v; e.d = d; e.c = c; e.r = r;
    e.ev = ev; e.emin = emin; e.emax = emax; e.eavg = eavg; e.eovr = eovr; e.efill = efill;
    tbl.push_back(e);
  endfunction

  initial begin
    reset          = 1'b1;
    bus.dur_valid  = 1'b0;
    bus.dur_in     = '0;
    bus.clear      = 1'b0;
    bus.stat_ready = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset_init");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    //   v  d    c  r   ev min max avg ovr fill
    // Basic window
    add(1, 10,  0, 1,  0,  0,  0,  0, 0, 1);
    add(1, 20,  0, 1,  0,  0,  0,  0, 0, 2);
    add(1, 30,  0, 1,  0,  0,  0,  0, 0, 3);
    add(1, 40,  0, 1,  1, 10, 40, 25, 0, 0);
    add(0, 0,   0, 1,  0, 10, 40, 25, 0, 0);
    // Truncation and zero rejection
    add(1, 1,   0, 1,  0, 10, 40, 25, 0, 1);
    add(1, 0,   0, 1,  0, 10, 40, 25, 0, 1);
    add(1, 2,   0, 1,  0, 10, 40, 25, 0, 2);
    add(1, 2,   0, 1,  0, 10, 40, 25, 0, 3);
    add(1, 0,   0, 1,  0, 10, 40, 25, 0, 3);
    add(1, 2,   0, 1,  1,  1,  2,  1, 0, 0);
    add(0, 0,   0, 1,  0,  1,  2,  1, 0, 0);
    // Backpressure and overrun
    add(1, 5,   0, 0,  0,  1,  2,  1, 0, 1);
    add(1, 5,   0, 0,  0,  1,  2,  1, 0, 2);
    add(1, 5,   0, 0,  0,  1,  2,  1, 0, 3);
    add(1, 5,   0, 0,  1,  5,  5,  5, 0, 0);
    add(1, 9,   0, 0,  1,  5,  5,  5, 0, 1);
    add(1, 9,   0, 0,  1,  5,  5,  5, 0, 2);
    add(1, 9,   0, 0,  1,  5,  5,  5, 0, 3);
    add(1, 9,   0, 0,  1,  5,  5,  5, 1, 0);
    add(0, 0,   0, 1,  0,  5,  5,  5, 1, 0);
    add(0, 0,   0, 0,  0,  5,  5,  5, 1, 0);
    add(0, 0,   1, 0,  0,  5,  5,  5, 0, 0);
    // Handshake coincident with window completion
    add(1, 3,   0, 0,  0,  5,  5,  5, 0, 1);
    add(1, 3,   0, 0,  0,  5,  5,  5, 0, 2);
    add(1, 3,   0, 0,  0,  5,  5,  5, 0, 3);
    add(1, 3,   0, 0,  1,  3,  3,  3, 0, 0);
    add(1, 7,   0, 0,  1,  3,  3,  3, 0, 1);
    add(1, 8,   0, 0,  1,  3,  3,  3, 0, 2);
    add(1, 9,   0, 0,  1,  3,  3,  3, 0, 3);
    add(1, 8,   0, 1,  1,  7,  9,  8, 0, 0);
    add(0, 0,   0, 1,  0,  7,  9,  8, 0, 0);
    // Extremes
    add(1, 255, 0, 1,  0,  7,  9,  8, 0, 1);
    add(1, 255, 0, 1,  0,  7,  9,  8, 0, 2);
    add(1, 255, 0, 1,  0,  7,  9,  8, 0, 3);
    add(1, 255, 0, 1,  1, 255, 255, 255, 0, 0);
    add(1, 1,   0, 1,  0, 255, 255, 255, 0, 1);
    add(1, 255, 0, 1,  0, 255, 255, 255, 0, 2);
    add(1, 255, 0, 1,  0, 255, 255, 255, 0, 3);
    add(1, 255, 0, 1,  1,  1, 255, 191, 0, 0);
    // Clear coincident with a strobe: sample lost, outputs held
    add(1, 6,   0, 1,  0,  1, 255, 191, 0, 1);
    add(1, 50,  1, 1,  0,  1, 255, 191, 0, 0);
    add(0, 0,   0, 1,  0,  1, 255, 191, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_valid", i), 32'(bus.stat_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d.tbl_min", i),   32'(bus.min_out),    32'(tbl[i].emin));
      chk($sformatf("vec%0d.tbl_max", i),   32'(bus.max_out),    32'(tbl[i].emax));
      chk($sformatf("vec%0d.tbl_avg", i),   32'(bus.avg_out),    32'(tbl[i].eavg));
      chk($sformatf("vec%0d.tbl_ovr", i),   32'(bus.overrun),    32'(tbl[i].eovr));
      chk($sformatf("vec%0d.tbl_fill", i),  32'(bus.fill),       32'(tbl[i].efill));
    end

    // Reset mid-window: partial window discarded, next full window stands alone.
    step(1, 100, 0, 1, "rst_pre0");
    step(1, 100, 0, 1, "rst_pre1");
    pulse_reset("rst_mid");
    step(1, 4, 0, 1, "rst_post0");
    step(1, 4, 0, 1, "rst_post1");
    step(1, 4, 0, 1, "rst_post2");
    step(1, 4, 0, 1, "rst_post3");
    chk("rst_post.avg", 32'(bus.avg_out), 32'd4);
    chk("rst_post.valid", 32'(bus.stat_valid), 32'd1);
    step(0, 0, 0, 1, "rst_drain");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic       v, c, r;
      logic [7:0] d;
      v = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 1) == 1);
      step(v, d, c, r, "rand");
      if ($urandom_range(0, 399) == 0) pulse_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
